// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    // Controller states; encoding is fixed so it can be observed in debug dumps.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width needed to count WIDTH serial steps.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell used as the serial adder's only arithmetic slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and carry of three one-bit inputs.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed
// overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned     CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    // Single bit-slice shared by every step of the addition.
    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Accumulator with the new sum bit entering at the MSB; after WIDTH steps
    // the first (LSB) result bit has reached position 0.
    always_comb begin
        acc_next = WIDTH'({fa_sum, acc} >> 1);
        last_bit = (cnt == LAST);
    end

    // Controller, datapath shift registers and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= acc_next;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= acc_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry register holds the carry into the MSB here
                        ovf   <= carry ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8); honours SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {cout,sum} = a + b + cin, widened to W+1 bits.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return (W+1)'(x) + (W+1)'(y) + (W+1)'(c);
    endfunction

    // Reference signed overflow: operands agree in sign, result sign differs.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W:0] r;
        r = ref_add(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Present operands and pulse start for one edge; returns at the next negedge.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        @(negedge clk);
        a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting busy cycles seen on the way.
    task automatic wait_done(output int nbusy, output bit timeout, output bit overlap);
        nbusy = 0; timeout = 1'b1; overlap = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) bad = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            if (ovf !== 1'b0) bad = 1'b1;
`endif
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b sum=%h cout=%b, required all zero",
                     busy, done, sum, cout);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] xa [3] = '{8'h35, 8'hFF, 8'hFF};
        logic [W-1:0] xb [3] = '{8'h4A, 8'hFF, 8'h01};
        logic         xc [3] = '{1'b0, 1'b1, 1'b0};
        logic [W:0]   exp_r [3] = '{9'h07F, 9'h1FF, 9'h100};
        int nb; bit to, ov;
        for (int i = 0; i < 3; i++) begin
            start_op(xa[i], xb[i], xc[i]);
            wait_done(nb, to, ov);
            checks++;
            if (to || nb != int'(W) || ov) begin
                errors++;
                $display("FAIL directed%0d_timing: busy_cycles=%0d timeout=%b overlap=%b, required %0d,0,0",
                         i, nb, to, ov, W);
            end
            checks++;
            if ({cout, sum} !== exp_r[i]) begin
                errors++;
                $display("FAIL directed%0d_result: {cout,sum}=%h, required %h", i, {cout, sum}, exp_r[i]);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                errors++;
                $display("FAIL directed%0d_ovf: ovf=%b, required 0", i, ovf);
            end
`endif
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || {cout, sum} !== exp_r[i]) begin
                errors++;
                $display("FAIL directed%0d_pulse: done=%b {cout,sum}=%h, required 0 and %h",
                         i, done, {cout, sum}, exp_r[i]);
            end
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int nb; bit to, ov;
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(nb, to, ov);
        checks++;
        if (to || sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_7f_01: timeout=%b sum=%h cout=%b ovf=%b, required 80,0,1",
                     to, sum, cout, ovf);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] x, y; logic c; logic [W:0] r;
        int nb; bit to, ov;
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom); y = W'($urandom); c = 1'($urandom);
            r = ref_add(x, y, c);
            start_op(x, y, c);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            wait_done(nb, to, ov);
            checks++;
            if (to || nb != int'(W) || ov || {cout, sum} !== r) begin
                errors++;
                $display("FAIL random%0d: %h+%h+%b gave {cout,sum}=%h busy=%0d timeout=%b, required %h busy=%0d",
                         i, x, y, c, {cout, sum}, nb, to, r, W);
            end
`ifdef SERIAL_ADDER_OVF_EN
            checks++;
            if (ovf !== ref_ovf(x, y, c)) begin
                errors++;
                $display("FAIL random%0d_ovf: ovf=%b, required %b", i, ovf, ref_ovf(x, y, c));
            end
`endif
        end
    endtask

    task automatic test_ignore_start();
        int nb; bit to, ov, extra;
        start_op(8'h35, 8'h4A, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hC3; b = 8'h5A; cin = 1'b1;
        wait_done(nb, to, ov);
        checks++;
        if (to || nb != 5 || {cout, sum} !== 9'h07F) begin
            errors++;
            $display("FAIL ignore_start: {cout,sum}=%h busy_rest=%0d timeout=%b, required 07f,5,0",
                     {cout, sum}, nb, to);
        end
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy || sum !== 8'h7F) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ignore_start_quiet: busy=%b done=%b sum=%h, required 0,0,7f", busy, done, sum);
        end
    endtask

    task automatic test_back_to_back();
        int nb, n; bit to, ov, unstable;
        start_op(8'h05, 8'h06, 1'b0);
        wait_done(nb, to, ov);
        checks++;
        if (to || sum !== 8'h0B) begin
            errors++;
            $display("FAIL b2b_first: sum=%h timeout=%b, required 0b,0", sum, to);
        end
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; unstable = 1'b0;
        while (!done && n < 40) begin
            if (sum !== 8'h0B || cout !== 1'b0) unstable = 1'b1;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != int'(W) + 1 || !done) begin
            errors++;
            $display("FAIL b2b_latency: done after %0d cycles, required %0d", n, W + 1);
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL b2b_hold: result changed during RUN, required 0b held");
        end
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: {cout,sum}=%h, required 030", {cout, sum});
        end
    endtask

    task automatic test_abort();
        int nb; bit to, ov, extra;
        start_op(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b sum=%h cout=%b, required all zero",
                     busy, done, sum, cout);
        end
        rst = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL abort_no_done: activity seen after abort, required none");
        end
        start_op(8'h01, 8'h02, 1'b0);
        wait_done(nb, to, ov);
        checks++;
        if (to || nb != int'(W) || {cout, sum} !== 9'h003) begin
            errors++;
            $display("FAIL abort_next: {cout,sum}=%h busy=%0d timeout=%b, required 003,%0d,0",
                     {cout, sum}, nb, to, W);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
